encounter_ctrl: RTL and testbench
=================================

# encounter_ctrl

Overworld-side initiator for the battle screen. Counts player steps on grass and draws a random encounter from the LFSR. On an encounter it raises and holds the battle start level, then waits for the battle's run/done level. It latches the returned health and XP with wrap/underflow guards and derives the evolution count fed back to the battle and overworld sprites. It sits between the overworld movement logic and the battle block and is the sole owner of persistent player health/XP state.

## Interface
- MAX_HEALTH, 100: full health; reset and faint-restore value.
- ENCOUNTER_THRESH, 40: an encounter fires when rand_in < ENCOUNTER_THRESH.
- MIN_STEPS, 4: qualifying grass steps required before a draw is allowed.
- COOLDOWN_FRAMES, 30: frames after a battle during which steps are ignored.
- EVOL1_XP, 100; EVOL2_XP, 200: XP thresholds for evolution 1 and 2.

- clk_in  in  1  pixel clock; the only clock.
- rst_in  in  1  synchronous, active-high reset.
- frame_in  in  1  one-cycle pulse per frame (hcount_in==0 && vcount_in==0).
- step_in  in  1  one-cycle pulse when the player completes a tile move.
- grass_in  in  1  destination tile is grass; sampled with step_in.
- rand_in  in  8  LFSR value.
- battle_run_in  in  1  battle done/run level from the battle block.
- battle_health_in  in  8  health reported by the battle.
- battle_xp_in  in  8  XP reported by the battle.
- battle_start_out  out  1  held high for the whole battle.
- health_out  out  8  persistent player health; drives the battle health input.
- xp_out  out  8  persistent XP; drives the battle XP input.
- evol_count_out  out  8  evolution stage, 0..2.
- in_battle_out  out  1  high in WAIT_CLEAR and FIGHT; overworld freezes movement.
- fainted_out  out  1  one-cycle pulse when a battle ends with the player fainted.

## Operation
- States: IDLE, WAIT_CLEAR, FIGHT, RESULT, COOLDOWN.
- **IDLE**
  - step_in && grass_in → step_cnt++ (8-bit, saturates at 255).
  - step_in && !grass_in → step_cnt unchanged.
  - If step_in && grass_in && step_cnt+1 >= MIN_STEPS && rand_in < ENCOUNTER_THRESH: go to WAIT_CLEAR, set step_cnt←0 and battle_start_out←1.
- **WAIT_CLEAR**
  - The battle's run level is stale-high from the previous battle until it sees start.
  - Remain here until battle_run_in==0, then go to FIGHT.
  - A high battle_run_in here is never treated as done.
- **FIGHT**: battle_run_in==1 → go to RESULT.
- **RESULT** (exactly 1 cycle): battle_start_out←0, then go to COOLDOWN with frame_cnt←0.
  - Faint when battle_health_in==0 or battle_health_in>MAX_HEALTH (8-bit subtract wrap). Then health_out←MAX_HEALTH, xp_out unchanged, fainted_out pulses.
  - Otherwise health_out←battle_health_in.
  - Otherwise xp_out←battle_xp_in if battle_xp_in ≥ xp_out; else xp_out←255 (wrap guard, saturate).
  - evol_count_out ← 2 if the new xp ≥ EVOL2_XP, 1 if ≥ EVOL1_XP, else 0. Never decreases; the max of old and new is kept.
- **COOLDOWN**
  - frame_cnt++ on each frame_in.
  - When frame_cnt reaches COOLDOWN_FRAMES (counting that pulse), go to IDLE.
  - step_in is ignored.
- step_in in any state other than IDLE is ignored and does not change step_cnt.

## Timing
- Reset values: battle_start_out 0, health_out MAX_HEALTH, xp_out 0, evol_count_out 0, in_battle_out 0, fainted_out 0, state IDLE, step_cnt 0, frame_cnt 0.
- Reset mid-battle: all of the above are restored next cycle and battle_start_out drops immediately.
- All outputs are registered.
  - battle_start_out rises 1 cycle after the qualifying step_in.
  - It falls 2 cycles after the battle_run_in high that is accepted in FIGHT (FIGHT→RESULT, then the RESULT-cycle update).
- health_out, xp_out, evol_count_out and fainted_out update together, 1 cycle after entering RESULT. They are stable at all other times.
- Minimum gap from battle end to the next possible encounter: COOLDOWN_FRAMES frame_in pulses plus MIN_STEPS grass steps.
- Simultaneous step_in and frame_in in COOLDOWN: the frame counts and the step is dropped.
- battle_run_in toggling during RESULT or COOLDOWN has no effect.

## Test plan
- **Encounter draw:** reset; 3 grass steps with rand_in=10 → no start. 4th grass step with rand_in=10 → battle_start_out=1 and in_battle_out=1 next cycle, step_cnt=0. Repeat with rand_in=200 on the 4th step → no start.
- **Stale run:** battle_run_in held 1 when start rises, then 0 for 3 cycles, then 1 → battle_start_out stays 1 until the second high. Result latched 1 cycle after it; start falls.
- **Win:** xp_out=80; battle returns health 60, xp 130 → health_out=60, xp_out=130, evol_count_out=1, fainted_out=0.
- **Faint and wrap:** battle returns health 250 → health_out=100, fainted_out pulses 1 cycle, xp_out unchanged. Separately, xp_out=230, battle_xp 24 → xp_out=255, evol_count_out=2.
- **Cooldown:** after a battle, 10 grass steps with rand_in=0 and 29 frame_in → no start. 30th frame_in → IDLE; 4 more grass steps with rand_in=0 → start.
- **Reset mid-FIGHT:** rst_in for 1 cycle → battle_start_out=0, health_out=100, xp_out=0, evol_count_out=0 the next cycle.

Source files
------------

// File: rtl/encounter_ctrl.sv
// Overworld encounter initiator: counts grass steps, draws encounters from the LFSR,
// hands off to the battle block and owns the persistent player health/XP state.
module encounter_ctrl #(
   parameter int MAX_HEALTH       = 100,
   parameter int ENCOUNTER_THRESH = 40,
   parameter int MIN_STEPS        = 4,
   parameter int COOLDOWN_FRAMES  = 30,
   parameter int EVOL1_XP         = 100,
   parameter int EVOL2_XP         = 200
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       frame_in,
   input  logic       step_in,
   input  logic       grass_in,
   input  logic [7:0] rand_in,
   input  logic       battle_run_in,
   input  logic [7:0] battle_health_in,
   input  logic [7:0] battle_xp_in,
   output logic       battle_start_out,
   output logic [7:0] health_out,
   output logic [7:0] xp_out,
   output logic [7:0] evol_count_out,
   output logic       in_battle_out,
   output logic       fainted_out,
   output logic [2:0] state_dbg_out,
   output logic [7:0] step_cnt_dbg_out
);

   // Handshake: battle_start_out is a level held from the encounter until the
   // RESULT cycle; battle_run_in is a level that counts as "done" only once it
   // has been seen low after start rose (WAIT_CLEAR), then high again (FIGHT).
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_CLEAR = 3'd1,
      S_FIGHT      = 3'd2,
      S_RESULT     = 3'd3,
      S_COOLDOWN   = 3'd4
   } state_t;

   localparam logic [7:0] MAX_H   = 8'(MAX_HEALTH);
   localparam logic [7:0] ENC_T   = 8'(ENCOUNTER_THRESH);
   localparam logic [8:0] MIN_S   = 9'(MIN_STEPS);
   localparam logic [7:0] COOL_F  = 8'(COOLDOWN_FRAMES);
   localparam logic [7:0] EVOL1_T = 8'(EVOL1_XP);
   localparam logic [7:0] EVOL2_T = 8'(EVOL2_XP);

   state_t     state;
   logic [7:0] step_cnt;
   logic [7:0] frame_cnt;

   logic [8:0] step_next;
   logic       grass_step;
   logic       encounter;
   logic       faint;
   logic [7:0] xp_new;
   logic [7:0] evol_new;
   logic [7:0] evol_keep;

   assign step_next  = {1'b0, step_cnt} + 9'd1;
   assign grass_step = step_in && grass_in;
   assign encounter  = grass_step && (step_next >= MIN_S) && (rand_in < ENC_T);

   // Health above MAX_HEALTH means the battle's 8-bit subtract wrapped below zero.
   assign faint = (battle_health_in == 8'd0) || (battle_health_in > MAX_H);

   always_comb begin
      xp_new = xp_out;
      if (!faint) begin
         if (battle_xp_in >= xp_out) xp_new = battle_xp_in;
         else                        xp_new = 8'hFF;
      end
   end

   always_comb begin
      evol_new = 8'd0;
      if (xp_new >= EVOL2_T)      evol_new = 8'd2;
      else if (xp_new >= EVOL1_T) evol_new = 8'd1;
   end

   assign evol_keep = (evol_new > evol_count_out) ? evol_new : evol_count_out;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state            <= S_IDLE;
         step_cnt         <= 8'd0;
         frame_cnt        <= 8'd0;
         battle_start_out <= 1'b0;
         health_out       <= MAX_H;
         xp_out           <= 8'd0;
         evol_count_out   <= 8'd0;
         in_battle_out    <= 1'b0;
         fainted_out      <= 1'b0;
      end else begin
         fainted_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (encounter) begin
                  state            <= S_WAIT_CLEAR;
                  step_cnt         <= 8'd0;
                  battle_start_out <= 1'b1;
                  in_battle_out    <= 1'b1;
               end else if (grass_step && step_cnt != 8'hFF) begin
                  step_cnt <= step_cnt + 8'd1;
               end
            end
            S_WAIT_CLEAR: begin
               if (!battle_run_in) state <= S_FIGHT;
            end
            S_FIGHT: begin
               if (battle_run_in) begin
                  state         <= S_RESULT;
                  in_battle_out <= 1'b0;
               end
            end
            S_RESULT: begin
               battle_start_out <= 1'b0;
               frame_cnt        <= 8'd0;
               state            <= S_COOLDOWN;
               xp_out           <= xp_new;
               evol_count_out   <= evol_keep;
               if (faint) begin
                  health_out  <= MAX_H;
                  fainted_out <= 1'b1;
               end else begin
                  health_out <= battle_health_in;
               end
            end
            S_COOLDOWN: begin
               if (frame_in) begin
                  frame_cnt <= frame_cnt + 8'd1;
                  if (frame_cnt + 8'd1 >= COOL_F) state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign state_dbg_out    = state;
   assign step_cnt_dbg_out = step_cnt;

endmodule

// File: tb/tb_encounter_ctrl.sv
// Directed bench for encounter_ctrl: a vector table for the first encounter and
// win, then hand-written sequences for cooldown, faint, wrap guard and reset.
module tb_encounter_ctrl;

   localparam int ST_IDLE = 0, ST_WAIT = 1, ST_FIGHT = 2, ST_RESULT = 3, ST_COOL = 4;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       frame_in, step_in, grass_in, battle_run_in;
   logic [7:0] rand_in, battle_health_in, battle_xp_in;
   logic       battle_start_out, in_battle_out, fainted_out;
   logic [7:0] health_out, xp_out, evol_count_out, step_cnt_dbg_out;
   logic [2:0] state_dbg_out;

   int checks   = 0;
   int failures = 0;

   encounter_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_in(frame_in), .step_in(step_in),
      .grass_in(grass_in), .rand_in(rand_in), .battle_run_in(battle_run_in),
      .battle_health_in(battle_health_in), .battle_xp_in(battle_xp_in),
      .battle_start_out(battle_start_out), .health_out(health_out), .xp_out(xp_out),
      .evol_count_out(evol_count_out), .in_battle_out(in_battle_out),
      .fainted_out(fainted_out), .state_dbg_out(state_dbg_out),
      .step_cnt_dbg_out(step_cnt_dbg_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic       step, grass;
      logic [7:0] rnd;
      logic       run;
      logic [7:0] bh, bxp;
      int         st;
      logic       start, inb;
      int         cnt, hp, xp, evol;
      logic       faint;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic step, logic grass, logic [7:0] rnd, logic run,
                               logic [7:0] bh, logic [7:0] bxp, int st, logic start,
                               logic inb, int cnt, int hp, int xp, int evol, logic faint);
      vec_t v;
      v.step = step; v.grass = grass; v.rnd = rnd; v.run = run; v.bh = bh; v.bxp = bxp;
      v.st = st; v.start = start; v.inb = inb; v.cnt = cnt; v.hp = hp; v.xp = xp;
      v.evol = evol; v.faint = faint;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_inputs();
      frame_in = 1'b0; step_in = 1'b0; grass_in = 1'b0; rand_in = 8'd255;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_state"}, state_dbg_out, ST_IDLE);
      chk({tag, "_start"}, battle_start_out, 0);
      chk({tag, "_health"}, health_out, 100);
      chk({tag, "_xp"}, xp_out, 0);
      chk({tag, "_evol"}, evol_count_out, 0);
      chk({tag, "_inb"}, in_battle_out, 0);
      chk({tag, "_faint"}, fainted_out, 0);
      chk({tag, "_cnt"}, step_cnt_dbg_out, 0);
   endtask

   // Four grass steps with rand 0 from step_cnt 0; the fourth must start a battle.
   task automatic encounter(input string tag);
      for (int i = 0; i < 3; i++) begin
         step_in = 1'b1; grass_in = 1'b1; rand_in = 8'd0;
         tick();
      end
      chk({tag, "_pre_start"}, battle_start_out, 0);
      chk({tag, "_pre_cnt"}, step_cnt_dbg_out, 3);
      tick();
      clear_inputs();
      chk({tag, "_start"}, battle_start_out, 1);
      chk({tag, "_inb"}, in_battle_out, 1);
      chk({tag, "_state"}, state_dbg_out, ST_WAIT);
      chk({tag, "_cnt"}, step_cnt_dbg_out, 0);
   endtask

   // Stale-high run, 3 low cycles, then the real done level carrying the result.
   task automatic run_battle(input string tag, input logic [7:0] bh, input logic [7:0] bxp,
                             input int exp_hp, input int exp_xp, input int exp_evol,
                             input int exp_faint);
      battle_run_in = 1'b1;
      tick();
      chk({tag, "_stale"}, state_dbg_out, ST_WAIT);
      battle_run_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk({tag, "_fight"}, state_dbg_out, ST_FIGHT);
      chk({tag, "_fight_start"}, battle_start_out, 1);
      battle_run_in = 1'b1; battle_health_in = bh; battle_xp_in = bxp;
      tick();
      chk({tag, "_result"}, state_dbg_out, ST_RESULT);
      chk({tag, "_result_start"}, battle_start_out, 1);
      chk({tag, "_result_inb"}, in_battle_out, 0);
      chk({tag, "_result_faint"}, fainted_out, 0);
      tick();
      battle_run_in = 1'b0;
      chk({tag, "_cool"}, state_dbg_out, ST_COOL);
      chk({tag, "_start_fall"}, battle_start_out, 0);
      chk({tag, "_hp"}, health_out, exp_hp);
      chk({tag, "_xp"}, xp_out, exp_xp);
      chk({tag, "_evol"}, evol_count_out, exp_evol);
      chk({tag, "_faint"}, fainted_out, exp_faint);
      battle_health_in = 8'd7; battle_xp_in = 8'd3;
      tick();
      chk({tag, "_faint_end"}, fainted_out, 0);
      chk({tag, "_hp_hold"}, health_out, exp_hp);
      chk({tag, "_xp_hold"}, xp_out, exp_xp);
   endtask

   // 29 frames keep COOLDOWN despite grass steps; the 30th frame (with a
   // simultaneous step that must be dropped) returns to IDLE.
   task automatic cooldown(input string tag);
      for (int i = 0; i < 29; i++) begin
         frame_in = 1'b1; step_in = (i % 3 == 0); grass_in = 1'b1; rand_in = 8'd0;
         battle_run_in = (i % 2 == 0);
         tick();
      end
      chk({tag, "_29_state"}, state_dbg_out, ST_COOL);
      chk({tag, "_29_start"}, battle_start_out, 0);
      chk({tag, "_29_cnt"}, step_cnt_dbg_out, 0);
      frame_in = 1'b1; step_in = 1'b1; battle_run_in = 1'b0;
      tick();
      clear_inputs();
      chk({tag, "_30_state"}, state_dbg_out, ST_IDLE);
      chk({tag, "_30_cnt"}, step_cnt_dbg_out, 0);
   endtask

   initial begin
      rst_in = 1'b1; battle_run_in = 1'b0; battle_health_in = 8'd0; battle_xp_in = 8'd0;
      clear_inputs();
      tick(); tick();
      rst_in = 1'b0;
      chk_reset_state("reset");

      //                step grass rnd   run bh     bxp    state     st inb cnt hp   xp   ev f
      vecs[0]  = mk(1, 1, 8'd10,  0, 8'd0,  8'd0,   ST_IDLE,   0, 0, 1, 100, 0,   0, 0);
      vecs[1]  = mk(1, 1, 8'd10,  0, 8'd0,  8'd0,   ST_IDLE,   0, 0, 2, 100, 0,   0, 0);
      vecs[2]  = mk(1, 0, 8'd0,   0, 8'd0,  8'd0,   ST_IDLE,   0, 0, 2, 100, 0,   0, 0);
      vecs[3]  = mk(1, 1, 8'd10,  0, 8'd0,  8'd0,   ST_IDLE,   0, 0, 3, 100, 0,   0, 0);
      vecs[4]  = mk(0, 1, 8'd0,   0, 8'd0,  8'd0,   ST_IDLE,   0, 0, 3, 100, 0,   0, 0);
      vecs[5]  = mk(1, 1, 8'd200, 0, 8'd0,  8'd0,   ST_IDLE,   0, 0, 4, 100, 0,   0, 0);
      vecs[6]  = mk(1, 1, 8'd10,  1, 8'd0,  8'd0,   ST_WAIT,   1, 1, 0, 100, 0,   0, 0);
      vecs[7]  = mk(1, 1, 8'd0,   1, 8'd0,  8'd0,   ST_WAIT,   1, 1, 0, 100, 0,   0, 0);
      vecs[8]  = mk(1, 1, 8'd0,   0, 8'd0,  8'd0,   ST_FIGHT,  1, 1, 0, 100, 0,   0, 0);
      vecs[9]  = mk(0, 0, 8'd0,   0, 8'd0,  8'd0,   ST_FIGHT,  1, 1, 0, 100, 0,   0, 0);
      vecs[10] = mk(0, 0, 8'd0,   0, 8'd60, 8'd130, ST_FIGHT,  1, 1, 0, 100, 0,   0, 0);
      vecs[11] = mk(0, 0, 8'd0,   1, 8'd60, 8'd130, ST_RESULT, 1, 0, 0, 100, 0,   0, 0);
      vecs[12] = mk(0, 0, 8'd0,   0, 8'd60, 8'd130, ST_COOL,   0, 0, 0, 60,  130, 1, 0);

      for (int i = 0; i < 13; i++) begin
         step_in = vecs[i].step; grass_in = vecs[i].grass; rand_in = vecs[i].rnd;
         battle_run_in = vecs[i].run; battle_health_in = vecs[i].bh;
         battle_xp_in = vecs[i].bxp; frame_in = 1'b0;
         tick();
         chk($sformatf("vec%0d_state", i), state_dbg_out, vecs[i].st);
         chk($sformatf("vec%0d_start", i), battle_start_out, vecs[i].start);
         chk($sformatf("vec%0d_inb", i), in_battle_out, vecs[i].inb);
         chk($sformatf("vec%0d_cnt", i), step_cnt_dbg_out, vecs[i].cnt);
         chk($sformatf("vec%0d_hp", i), health_out, vecs[i].hp);
         chk($sformatf("vec%0d_xp", i), xp_out, vecs[i].xp);
         chk($sformatf("vec%0d_evol", i), evol_count_out, vecs[i].evol);
         chk($sformatf("vec%0d_faint", i), fainted_out, vecs[i].faint);
      end
      clear_inputs();
      battle_run_in = 1'b0;

      cooldown("cd1");
      encounter("enc1");
      run_battle("faint_wrap", 8'd250, 8'd5, 100, 130, 1, 1);

      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk_reset_state("reset_cool");

      encounter("enc2");
      run_battle("win80", 8'd90, 8'd80, 90, 80, 0, 0);
      cooldown("cd2");
      encounter("enc3");
      run_battle("win130", 8'd60, 8'd130, 60, 130, 1, 0);
      cooldown("cd3");
      encounter("enc4");
      run_battle("hp_max", 8'd100, 8'd230, 100, 230, 2, 0);
      cooldown("cd4");
      encounter("enc5");
      run_battle("xp_wrap", 8'd1, 8'd24, 1, 255, 2, 0);
      cooldown("cd5");
      encounter("enc6");
      run_battle("hp_zero", 8'd0, 8'd50, 100, 255, 2, 1);
      cooldown("cd6");

      encounter("enc7");
      battle_run_in = 1'b0;
      tick();
      chk("midfight_state", state_dbg_out, ST_FIGHT);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk_reset_state("reset_fight");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
